// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the MEM/WB stage: load funct3 encodings,
// write-back control bit positions, the stage register layout and
// sub-word extension helpers.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [2:0]  funct3;
        logic [1:0]  addr;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } mem_wb_reg_t;

    // Extend a byte to 32 bits, sign-extending when i_sgn is set.
    function automatic logic [31:0] ext_byte(input logic [7:0] i_b, input logic i_sgn);
        return {{24{i_sgn & i_b[7]}}, i_b};
    endfunction

    // Extend a halfword to 32 bits, sign-extending when i_sgn is set.
    function automatic logic [31:0] ext_half(input logic [15:0] i_h, input logic i_sgn);
        return {{16{i_sgn & i_h[15]}}, i_h};
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bus. The master (memory stage side) drives the instruction
// fields and pipeline control; the slave (the MEM/WB stage) drives the
// register-file write port and forwarding outputs.
// Optional macro: INSTRET_EN adds the 64-bit INSTRET output.
interface mem_wb_stage_if;
    logic        VALID_IN;
    logic        STALL;
    logic        FLUSH;
    logic [1:0]  CRT_WB_IN;
    logic [31:0] DATA_IN;
    logic [31:0] ReadData;
    logic [2:0]  FUNCT3_IN;
    logic [4:0]  INST_IN;
    logic        WB_WE;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        FWD_VALID;
    logic        MISALIGN;
`ifdef INSTRET_EN
    logic [63:0] INSTRET;
`endif

    modport master (
        output VALID_IN, STALL, FLUSH, CRT_WB_IN, DATA_IN, ReadData, FUNCT3_IN, INST_IN,
        input  WB_WE, WB_RD, WB_DATA, FWD_VALID, MISALIGN
`ifdef INSTRET_EN
        , input INSTRET
`endif
    );

    modport slave (
        input  VALID_IN, STALL, FLUSH, CRT_WB_IN, DATA_IN, ReadData, FUNCT3_IN, INST_IN,
        output WB_WE, WB_RD, WB_DATA, FWD_VALID, MISALIGN
`ifdef INSTRET_EN
        , output INSTRET
`endif
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load alignment: selects the byte/halfword lane from the
// word-aligned read data, extends it, and flags misaligned halfword/word
// accesses. Misaligned accesses still return the lane chosen by the upper
// address bits.
module load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the byte and halfword lanes addressed by the low address bits.
    always_comb begin
        w_byte = 8'd0;
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'd0;
        endcase
        if (i_addr[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
    end

    // Extend the selected lane per load type and flag misalignment.
    always_comb begin
        o_data     = i_word;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_LB:   o_data = ext_byte(w_byte, 1'b1);
            F3_LBU:  o_data = ext_byte(w_byte, 1'b0);
            F3_LH: begin
                o_data     = ext_half(w_half, 1'b1);
                o_misalign = i_addr[0];
            end
            F3_LHU: begin
                o_data     = ext_half(w_half, 1'b0);
                o_misalign = i_addr[0];
            end
            F3_LW: begin
                o_data     = i_word;
                o_misalign = (i_addr != 2'd0);
            end
            default: begin
                o_data     = i_word;
                o_misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage of the RV32I core. Registers the memory-stage
// results, aligns sub-word loads and drives the register-file write port
// and forwarding outputs purely from the stage register.
// Optional macro: INSTRET_EN adds a 64-bit retired-instruction counter.
module mem_wb_stage
    import rv32i_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    mem_wb_reg_t r_stage;
    mem_wb_reg_t w_stage_next;
    logic [31:0] w_load_data;
    logic        w_load_mis;

    // Stage update: a flush inserts a bubble, a stall holds, otherwise capture.
    always_comb begin
        w_stage_next = r_stage;
        if (bus.FLUSH) begin
            w_stage_next = '0;
        end else if (bus.STALL) begin
            w_stage_next = r_stage;
        end else begin
            w_stage_next.valid      = bus.VALID_IN;
            w_stage_next.reg_write  = bus.CRT_WB_IN[WB_REGWRITE];
            w_stage_next.mem_to_reg = bus.CRT_WB_IN[WB_MEMTOREG];
            w_stage_next.funct3     = bus.FUNCT3_IN;
            w_stage_next.addr       = bus.DATA_IN[1:0];
            w_stage_next.alu        = bus.DATA_IN;
            w_stage_next.rdata      = bus.ReadData;
            w_stage_next.rd         = bus.INST_IN;
        end
    end

    // Stage register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_stage_next;
        end
    end

    load_align u_load_align (
        .i_word     (r_stage.rdata),
        .i_addr     (r_stage.addr),
        .i_funct3   (r_stage.funct3),
        .o_data     (w_load_data),
        .o_misalign (w_load_mis)
    );

    // Writes to x0 are dropped here so the register file never sees them.
    assign bus.WB_WE     = r_stage.valid & r_stage.reg_write & (r_stage.rd != 5'd0);
    assign bus.WB_RD     = r_stage.rd;
    assign bus.WB_DATA   = r_stage.mem_to_reg ? w_load_data : r_stage.alu;
    assign bus.FWD_VALID = bus.WB_WE;
    assign bus.MISALIGN  = r_stage.valid & r_stage.mem_to_reg & w_load_mis;

`ifdef INSTRET_EN
    logic [63:0] r_instret;

    // Count each instruction leaving the stage; bubbles and stalled cycles do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= 64'd0;
        end else if (r_stage.valid && !bus.STALL) begin
            r_instret <= r_instret + 64'd1;
        end else begin
            r_instret <= r_instret;
        end
    end

    assign bus.INSTRET = r_instret;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: each stimulus step pushes the
// hand-computed outputs expected after its clock edge; a monitor pops and
// compares one entry per edge. INSTRET checks are built with INSTRET_EN.
module tb_mem_wb_stage;

    typedef struct {
        string       nm;
        logic        cwb;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        cir;
        logic [63:0] ir;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb_q[$];

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // Monitor: one expected entry per clock edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.cwb) begin
                    chk({e.nm, ".we"},   64'(bus.WB_WE),     64'(e.we));
                    chk({e.nm, ".fwd"},  64'(bus.FWD_VALID), 64'(e.we));
                    chk({e.nm, ".rd"},   64'(bus.WB_RD),     64'(e.rd));
                    chk({e.nm, ".data"}, 64'(bus.WB_DATA),   64'(e.data));
                    chk({e.nm, ".mis"},  64'(bus.MISALIGN),  64'(e.mis));
                end
`ifdef INSTRET_EN
                if (e.cir) begin
                    chk({e.nm, ".instret"}, bus.INSTRET, e.ir);
                end
`endif
            end
        end
    end

    // Drive one cycle of inputs, queue the expected result, and pass the edge.
    task automatic step(input string nm, input logic r, input logic v, input logic st,
                        input logic fl, input logic [1:0] crt, input logic [31:0] d,
                        input logic [31:0] rw, input logic [2:0] f3, input logic [4:0] rd,
                        input logic cwb, input logic ewe, input logic [4:0] erd,
                        input logic [31:0] edat, input logic emis,
                        input logic cir, input logic [63:0] eir);
        exp_t e;
        rst           = r;
        bus.VALID_IN  = v;
        bus.STALL     = st;
        bus.FLUSH     = fl;
        bus.CRT_WB_IN = crt;
        bus.DATA_IN   = d;
        bus.ReadData  = rw;
        bus.FUNCT3_IN = f3;
        bus.INST_IN   = rd;
        e.nm = nm; e.cwb = cwb; e.we = ewe; e.rd = erd; e.data = edat; e.mis = emis;
        e.cir = cir; e.ir = eir;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // ALU-only instruction with WB checks, no INSTRET check.
    task automatic alu(input string nm, input logic r, input logic v, input logic st,
                       input logic fl, input logic [1:0] crt, input logic [31:0] d,
                       input logic [4:0] rd, input logic ewe, input logic [4:0] erd,
                       input logic [31:0] edat);
        step(nm, r, v, st, fl, crt, d, 32'h0, 3'b010, rd, 1'b1, ewe, erd, edat, 1'b0, 1'b0, 64'd0);
    endtask

    // Load instruction with WB checks.
    task automatic ld(input string nm, input logic [31:0] a, input logic [31:0] w,
                      input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] edat,
                      input logic emis);
        step(nm, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, a, w, f3, rd, 1'b1, 1'b1, rd, edat, emis, 1'b0, 64'd0);
    endtask

    // INSTRET-only step: valid ALU op with rd = data = n.
    task automatic irs(input string nm, input logic v, input logic st, input logic [4:0] n,
                       input logic [63:0] eir);
        step(nm, 1'b0, v, st, 1'b0, 2'b01, {27'd0, n}, 32'h0, 3'b010, n, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, eir);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.VALID_IN = 1'b0; bus.STALL = 1'b0; bus.FLUSH = 1'b0; bus.CRT_WB_IN = 2'b00;
        bus.DATA_IN = 32'h0; bus.ReadData = 32'h0; bus.FUNCT3_IN = 3'b000; bus.INST_IN = 5'd0;

        step("reset0", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 32'h3, 32'hFFFF_FFFF, 3'b000, 5'd3,
             1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 64'd0);
        step("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3'b000, 5'd0,
             1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 64'd0);

        // Sub-word loads from word 0x80FF7F01 / 0x80011234.
        ld("lb_l3",  32'h0000_1003, 32'h80FF_7F01, 3'b000, 5'd1, 32'hFFFF_FF80, 1'b0);
        ld("lbu_l3", 32'h0000_1003, 32'h80FF_7F01, 3'b100, 5'd2, 32'h0000_0080, 1'b0);
        ld("lb_l0",  32'h0000_1000, 32'h80FF_7F01, 3'b000, 5'd3, 32'h0000_0001, 1'b0);
        ld("lb_l1",  32'h0000_1001, 32'h80FF_7F01, 3'b000, 5'd3, 32'h0000_007F, 1'b0);
        ld("lb_l2",  32'h0000_1002, 32'h80FF_7F01, 3'b000, 5'd4, 32'hFFFF_FFFF, 1'b0);
        ld("lh_hi",  32'h0000_2002, 32'h8001_1234, 3'b001, 5'd6, 32'hFFFF_8001, 1'b0);
        ld("lhu_hi", 32'h0000_2002, 32'h8001_1234, 3'b101, 5'd6, 32'h0000_8001, 1'b0);
        ld("lh_mis", 32'h0000_2001, 32'h8001_1234, 3'b001, 5'd6, 32'h0000_1234, 1'b1);
        ld("lhu_m3", 32'h0000_2003, 32'h8001_1234, 3'b101, 5'd6, 32'h0000_8001, 1'b1);
        ld("lw_mis", 32'h0000_2002, 32'h8001_1234, 3'b010, 5'd8, 32'h8001_1234, 1'b1);
        ld("lw_ok",  32'h0000_2000, 32'h8001_1234, 3'b010, 5'd8, 32'h8001_1234, 1'b0);
        ld("f3_011", 32'h0000_2003, 32'h8001_1234, 3'b011, 5'd8, 32'h8001_1234, 1'b0);

        // ALU write-back, x0 suppression, no-write and bubble cases.
        alu("alu_rd5",  1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'hDEAD_BEEF, 5'd5, 1'b1, 5'd5, 32'hDEAD_BEEF);
        alu("alu_rd0",  1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'hDEAD_BEEF, 5'd0, 1'b0, 5'd0, 32'hDEAD_BEEF);
        alu("no_rw",    1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0042, 5'd9, 1'b0, 5'd9, 32'h0000_0042);
        alu("bubble",   1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0011, 5'd9, 1'b0, 5'd9, 32'h0000_0011);
        alu("alu_addr", 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0003, 5'd9, 1'b1, 5'd9, 32'h0000_0003);
        step("bub_mis", 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h2, 32'h8001_1234, 3'b010, 5'd9,
             1'b1, 1'b0, 5'd9, 32'h8001_1234, 1'b0, 1'b0, 64'd0);

        // Stall freezes rd=7 for 3 cycles, then flush+stall yields a bubble.
        alu("pre_st", 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0777, 5'd7, 1'b1, 5'd7, 32'h0000_0777);
        for (int i = 0; i < 3; i++) begin
            alu("stall", 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_AAAA, 5'd8, 1'b1, 5'd7, 32'h0000_0777);
        end
        alu("fl_st",  1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_AAAA, 5'd8, 1'b0, 5'd0, 32'h0);
        alu("pre_fl", 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0123, 5'd7, 1'b1, 5'd7, 32'h0000_0123);
        alu("flush",  1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0456, 5'd8, 1'b0, 5'd0, 32'h0);

        // Reset in the middle of a load stream and in the middle of a stall.
        ld("stream", 32'h0000_1003, 32'h80FF_7F01, 3'b000, 5'd1, 32'hFFFF_FF80, 1'b0);
        step("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_2002, 32'h8001_1234, 3'b010, 5'd2,
             1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 64'd0);
        alu("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_1234, 5'd10, 1'b1, 5'd10, 32'h0000_1234);
        alu("rst_st",   1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_5555, 5'd11, 1'b0, 5'd0, 32'h0);

`ifdef INSTRET_EN
        // Ten instructions, bubbles and two stall cycles: count reaches 10.
        irs("ir_v1", 1'b1, 1'b0, 5'd1, 64'd0);
        irs("ir_v2", 1'b1, 1'b0, 5'd2, 64'd1);
        irs("ir_v3", 1'b1, 1'b0, 5'd0, 64'd2);
        irs("ir_v4", 1'b1, 1'b0, 5'd4, 64'd3);
        irs("ir_v5", 1'b1, 1'b0, 5'd5, 64'd4);
        irs("ir_b1", 1'b0, 1'b0, 5'd0, 64'd5);
        irs("ir_b2", 1'b0, 1'b0, 5'd0, 64'd5);
        irs("ir_v6", 1'b1, 1'b0, 5'd6, 64'd5);
        irs("ir_s1", 1'b1, 1'b1, 5'd9, 64'd5);
        irs("ir_s2", 1'b1, 1'b1, 5'd9, 64'd5);
        irs("ir_v7", 1'b1, 1'b0, 5'd7, 64'd6);
        irs("ir_v8", 1'b1, 1'b0, 5'd8, 64'd7);
        irs("ir_v9", 1'b1, 1'b0, 5'd9, 64'd8);
        irs("ir_v10", 1'b1, 1'b0, 5'd10, 64'd9);
        irs("ir_b3", 1'b0, 1'b0, 5'd0, 64'd10);
        irs("ir_b4", 1'b0, 1'b0, 5'd0, 64'd10);
        // Wrap-around from all ones.
        irs("ir_pre", 1'b1, 1'b0, 5'd1, 64'd10);
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        irs("ir_wrap0", 1'b1, 1'b0, 5'd2, 64'd0);
        irs("ir_wrap1", 1'b0, 1'b0, 5'd0, 64'd1);
`endif

        rst = 1'b0; bus.VALID_IN = 1'b0; bus.STALL = 1'b0; bus.FLUSH = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
